// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: assembles scanner keys into a 6-digit BCD hhmmss buffer and forwards Enter/Esc events.
// Latency: a key acts two edges after its strobe is first sampled (synchroniser), so effects are visible after edge N+2.
// Backpressure: none; one action per key edge, and clrBuffer or a mode change wins over a key in the same cycle.
module keypad_entry_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  key_in,
    input  logic        key_strobe,
    input  logic [1:0]  mode,
    input  logic        clrBuffer,
    output logic [23:0] hhmmss,
    output logic [2:0]  digit_count,
    output logic        entry_valid,
    output logic [1:0]  KeyCode,
    output logic        KeyCodeAvailable,
    output logic        entry_error
);

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_ESC   = 4'hB;
    localparam logic [3:0] KEY_BKSP  = 4'hC;
    localparam logic [1:0] KC_ENTER  = 2'b01;
    localparam logic [1:0] KC_ESC    = 2'b10;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [1:0]  r_last_mode;
    logic [23:0] r_hhmmss;
    logic [2:0]  r_count;
    logic [1:0]  r_keycode;
    logic        r_kca;
    logic        r_err;

    logic        w_key_evt;
    logic        w_set_mode;
    logic        w_hh_ok;
    logic        w_mm_ok;
    logic        w_ss_ok;
    logic        w_entry_valid;

    // Strobe is asynchronous: two-flop synchroniser plus a delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= key_strobe;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_key_evt  = r_sync2 & ~r_prev;
    // Mode 11 behaves as display; only 01 and 10 edit the buffer.
    assign w_set_mode = (mode == 2'b01) || (mode == 2'b10);

    // Digits are always 0-9, so range checks only need the tens digit plus the units digit for hour 2x.
    assign w_hh_ok = (r_hhmmss[23:20] < 4'd2) ||
                     ((r_hhmmss[23:20] == 4'd2) && (r_hhmmss[19:16] <= 4'd3));
    assign w_mm_ok = (r_hhmmss[15:12] <= 4'd5);
    assign w_ss_ok = (r_hhmmss[7:4]   <= 4'd5);
    assign w_entry_valid = (r_count == 3'd6) && w_hh_ok && w_mm_ok && w_ss_ok;

    // Buffer, count and event registers: clear request, then mode change, then key event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_mode <= 2'b00;
            r_hhmmss    <= 24'h0;
            r_count     <= 3'd0;
            r_keycode   <= 2'b00;
            r_kca       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_kca <= 1'b0;
            r_err <= 1'b0;
            if (clrBuffer) begin
                r_hhmmss <= 24'h0;
                r_count  <= 3'd0;
            end else if (mode != r_last_mode) begin
                r_last_mode <= mode;
                r_hhmmss    <= 24'h0;
                r_count     <= 3'd0;
            end else if (w_key_evt) begin
                if (key_in <= 4'd9) begin
                    if (w_set_mode && (r_count < 3'd6)) begin
                        r_hhmmss <= {r_hhmmss[19:0], key_in};
                        r_count  <= r_count + 3'd1;
                    end
                end else if (key_in == KEY_BKSP) begin
                    if (w_set_mode && (r_count != 3'd0)) begin
                        r_hhmmss <= {4'h0, r_hhmmss[23:4]};
                        r_count  <= r_count - 3'd1;
                    end
                end else if (key_in == KEY_ENTER) begin
                    if (!w_set_mode || w_entry_valid) begin
                        // Buffer is held so the controller can capture it next cycle.
                        r_keycode <= KC_ENTER;
                        r_kca     <= 1'b1;
                    end else begin
                        r_err    <= 1'b1;
                        r_hhmmss <= 24'h0;
                        r_count  <= 3'd0;
                    end
                end else if (key_in == KEY_ESC) begin
                    r_keycode <= KC_ESC;
                    r_kca     <= 1'b1;
                    r_hhmmss  <= 24'h0;
                    r_count   <= 3'd0;
                end
            end
        end
    end

    assign hhmmss           = r_hhmmss;
    assign digit_count      = r_count;
    assign entry_valid      = w_entry_valid;
    assign KeyCode          = r_keycode;
    assign KeyCodeAvailable = r_kca;
    assign entry_error      = r_err;

endmodule

// File: doc/keypad_entry_buffer.md
# keypad_entry_buffer

Collects keypad presses from the front-panel scanner and assembles them into a 6-digit BCD hhmmss entry buffer. It also turns Enter/Esc presses into the single-cycle KeyCode/KeyCodeAvailable events consumed by clock_time_alarm_controller. It sits directly upstream of that controller: its hhmmss output drives the controller's hhmmss input, and the controller's clrBuffer output clears it. Digit entries are range-checked, so an out-of-range time never reaches the controller as an Enter.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- key_in  input  4  key code from scanner: 0–9 digit, 4'hA Enter, 4'hB Esc, 4'hC Backspace, 4'hD–4'hF ignored; stable while key_strobe high
- key_strobe  input  1  asynchronous level, high while a key is held
- mode  input  2  00 display, 01 set clock, 10 set alarm, 11 treated as display
- clrBuffer  input  1  single-cycle clear request from controller
- hhmmss  output  24  BCD entry buffer {H1,H0,M1,M0,S1,S0}, newest digit in [3:0]
- digit_count  output  3  digits entered, 0–6
- entry_valid  output  1  combinational: digit_count==6 and HH≤23, MM≤59, SS≤59
- KeyCode  output  2  01 Enter, 10 Esc; holds last forwarded value
- KeyCodeAvailable  output  1  one-cycle pulse when KeyCode is updated
- entry_error  output  1  one-cycle pulse when Enter is rejected

## Operation
- Reset values: hhmmss=0, digit_count=0, KeyCode=00, KeyCodeAvailable=0, entry_error=0, synchroniser and edge flops=0, last_mode=00.
- key_strobe passes through a 2-flop synchroniser, then rising-edge detect (sync2 & ~prev). One edge produces exactly one key event; holding the key produces no repeats.
- On a key event, key_in is sampled directly. It is guaranteed stable while strobe is high.
- Priority per cycle, highest first: clrBuffer, mode change, key event.
- clrBuffer: hhmmss=0, digit_count=0. A key event in the same cycle is dropped. KeyCode is unchanged.
- Mode change (mode != last_mode): last_mode<=mode, hhmmss=0, digit_count=0. A key event in the same cycle is dropped.
- Digit in mode 01/10:
  - If digit_count<6: hhmmss <= {hhmmss[19:0], digit}; count+1.
  - If digit_count==6: ignored, buffer unchanged.
- Backspace in mode 01/10:
  - If count>0: hhmmss <= {4'h0, hhmmss[23:4]}; count−1.
  - If count==0: no effect.
- Digits and Backspace in mode 00/11 are ignored.
- Enter in mode 01/10:
  - If entry_valid: KeyCode<=01 and KeyCodeAvailable pulse; buffer held.
  - Otherwise: entry_error pulse, hhmmss=0, count=0, no KeyCodeAvailable.
- Enter in mode 00/11: KeyCode<=01 and pulse are forwarded, no validation.
- Esc in any mode: KeyCode<=10, KeyCodeAvailable pulse, hhmmss=0, count=0.
- Codes D–F produce no effect.

## Timing
- key_strobe first sampled high at edge N: sync1 at N, sync2 at N+1. Action registers at edge N+2, so hhmmss, count, KeyCode, KeyCodeAvailable and entry_error are visible after N+2.
- KeyCodeAvailable and entry_error are high for exactly one cycle. They can never both be high.
- Minimum key spacing is strobe low for ≥2 cycles between presses. Shorter gaps may be merged and are not required to be handled.
- clrBuffer asserted at edge M: buffer reads 0 after M.
- Controller clrBuffer following an Enter arrives one cycle after KeyCodeAvailable, so the buffer stays stable for the controller's capture cycle.
- entry_valid follows hhmmss combinationally, with no added latency.
- Reset mid-press: state clears immediately. If strobe is still high after reset release, it registers as a new edge (prev=0).

## Test plan
- Reset, mode=01, keys 1,2,3,4,5,6 → hhmmss=24'h123456, count=6, entry_valid=1. A 7th key 9 leaves 24'h123456.
- Mode=01, keys 2,3,5,9,5,9 then Enter → KeyCode=01 with a one-cycle KeyCodeAvailable at N+2 of the Enter strobe, and hhmmss=24'h235959 held. Then clrBuffer pulse → hhmmss=0, count=0.
- Mode=10, keys 2,4,0,0,0,0 then Enter → entry_error pulse, no KeyCodeAvailable, hhmmss=0. Repeat with 1,2,6,0,0,0 → same rejection (MM=60).
- Mode=01, keys 1,2,3, Backspace, 4 → hhmmss=24'h000124, count=3. Backspace×4 → hhmmss=0, count=0.
- Mode=01, keys 1,2, then Esc → KeyCode=10, one pulse, hhmmss=0. Then change mode to 10 with 3 digits entered → buffer cleared. A key event in the same cycle as clrBuffer is dropped.
- key_strobe held high for 50 cycles with key 7 → exactly one digit entered. Assert reset mid-hold → all outputs 0. After release with strobe still high → one digit 7 entered.
